// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants and types for the register-file dump reader.
package regfile_dump_reader_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned NUM_REGS = 8;

   // A requested count of 0 means "the whole file".
   localparam int unsigned COUNT_ALL = NUM_REGS;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      SEND,
      DONE
   } state_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Output word stream: valid/ready handshake with a last-word qualifier.
interface regfile_dump_reader_if #(
   parameter int unsigned DATA_W = regfile_dump_reader_pkg::DATA_W
);

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a wrap-around range of register addresses, samples each word through
// the register file's combinational read port and streams it out.
module regfile_dump_reader #(
   parameter int unsigned DATA_W   = regfile_dump_reader_pkg::DATA_W,
   parameter int unsigned ADDR_W   = regfile_dump_reader_pkg::ADDR_W,
   parameter int unsigned NUM_REGS = regfile_dump_reader_pkg::NUM_REGS
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_addr,
   input  logic [ADDR_W:0]     count,
   output logic [ADDR_W-1:0]   rf_read_addr,
   input  logic [DATA_W-1:0]   rf_read_data,
   regfile_dump_reader_if.master stream,
   output logic                busy,
   output logic                done
);

   import regfile_dump_reader_pkg::*;

   localparam int unsigned CW = ADDR_W + 1;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W:0]   remaining;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W:0]   count_eff;
   logic              handshake;

   // Zero and out-of-range counts both collapse to a full-file dump.
   always_comb begin
      count_eff = count;
      if (count == '0) begin
         count_eff = CW'(COUNT_ALL);
      end else if (count > CW'(NUM_REGS)) begin
         count_eff = CW'(NUM_REGS);
      end
   end

   // A word is accepted only while it is being presented.
   always_comb begin
      handshake = (state_q == SEND) && stream.out_ready;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = READ;
         READ: state_d = SEND;
         SEND: begin
            if (handshake) begin
               state_d = (remaining > CW'(1)) ? READ : DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Address walk, remaining-word count and captured read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_addr  <= '0;
         remaining <= '0;
         data_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  cur_addr  <= start_addr;
                  remaining <= count_eff;
               end
            end
            READ: data_q <= rf_read_data;
            SEND: begin
               if (handshake && (remaining > CW'(1))) begin
                  remaining <= remaining - CW'(1);
                  cur_addr  <= cur_addr + ADDR_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state. remaining is frozen between READ and the
   // SEND handshake, so decoding out_last here equals registering it in READ.
   always_comb begin
      rf_read_addr     = cur_addr;
      stream.out_data  = data_q;
      stream.out_valid = (state_q == SEND);
      stream.out_last  = (state_q == SEND) && (remaining == CW'(1));
      busy             = (state_q != IDLE);
      done             = (state_q == DONE);
   end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;

   typedef struct {
      logic [7:0] data;
      logic       last;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [2:0] start_addr;
   logic [3:0] count;
   logic [2:0] rf_read_addr;
   logic [7:0] rf_read_data;
   logic       busy;
   logic       done;

   logic [7:0] rf    [8];
   logic [7:0] mem_m [8];

   exp_t exp_q[$];
   exp_t e;

   int tests_run  = 0;
   int failed     = 0;
   int cyc        = 0;
   int words_seen = 0;
   int prev_hs    = 0;
   int last_hs    = 0;
   bit rate_chk   = 1'b0;

   regfile_dump_reader_if bus ();

   regfile_dump_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .start_addr   (start_addr),
      .count        (count),
      .rf_read_addr (rf_read_addr),
      .rf_read_data (rf_read_data),
      .stream       (bus),
      .busy         (busy),
      .done         (done)
   );

   assign rf_read_data = rf[rf_read_addr];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Accepted words are compared against the expected stream.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_word", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("word_data", {24'd0, bus.out_data}, {24'd0, e.data});
            check("word_last", {31'd0, bus.out_last}, {31'd0, e.last});
         end
         words_seen++;
         if (rate_chk && words_seen > 1) check("rate", cyc - prev_hs, 2);
         prev_hs = cyc;
         if (bus.out_last) last_hs = cyc;
      end
   end

   task automatic push_dump(input logic [2:0] addr, input logic [3:0] cnt);
      int n;
      exp_t x;
      n = (cnt == 4'd0 || cnt > 4'd8) ? 8 : int'(cnt);
      for (int i = 0; i < n; i++) begin
         x.data = mem_m[(int'(addr) + i) % 8];
         x.last = (i == n - 1);
         exp_q.push_back(x);
      end
   endtask

   task automatic start_dump(input logic [2:0] addr, input logic [3:0] cnt);
      @(posedge clk); #1;
      start      = 1'b1;
      start_addr = addr;
      count      = cnt;
      words_seen = 0;
      push_dump(addr, cnt);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("valid_not_yet", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      check("first_valid_latency", {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic wait_done(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen = 1'b1;
      end
      check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
      if (seen) begin
         check({tag, "_done_timing"}, cyc - last_hs, 1);
         check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd1);
         @(negedge clk);
         check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
         check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
      end
      check({tag, "_queue_empty"}, exp_q.size(), 0);
   endtask

   task automatic wait_words(input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         if (words_seen >= n) ok = 1'b1;
      end
      check("wait_words", {31'd0, ok}, 32'd1);
   endtask

   task automatic wait_valid();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid === 1'b1) ok = 1'b1;
      end
      check("wait_valid", {31'd0, ok}, 32'd1);
   endtask

   initial begin
      logic [7:0] held;
      rst_n         = 1'b0;
      start         = 1'b0;
      start_addr    = '0;
      count         = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rf[i]    = 8'h10 + 8'(i);
         mem_m[i] = 8'h10 + 8'(i);
      end

      #23;
      check("rst_rf_read_addr", {29'd0, rf_read_addr}, 32'd0);
      check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      rst_n = 1'b1;

      // Full dump, ready held high.
      bus.out_ready = 1'b1;
      rate_chk      = 1'b1;
      start_dump(3'd0, 4'd0);
      wait_done("t1");
      rate_chk = 1'b0;
      check("t1_words", words_seen, 8);

      // Wrap-around partial dump.
      start_dump(3'd6, 4'd4);
      wait_done("t2");
      check("t2_words", words_seen, 4);

      // Single word held under backpressure.
      bus.out_ready = 1'b0;
      start_dump(3'd2, 4'd1);
      held = bus.out_data;
      check("t3_first_data", {24'd0, held}, 32'h12);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("t3_hold_valid", {31'd0, bus.out_valid}, 32'd1);
         check("t3_hold_last", {31'd0, bus.out_last}, 32'd1);
         check("t3_hold_data", {24'd0, bus.out_data}, {24'd0, held});
      end
      bus.out_ready = 1'b1;
      wait_done("t3");

      // A second start during a dump must be ignored.
      start_dump(3'd0, 4'd0);
      repeat (3) begin
         @(posedge clk); #1;
      end
      start      = 1'b1;
      start_addr = 3'd5;
      count      = 4'd2;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("t4");
      check("t4_words", words_seen, 8);

      // Register 3 rewritten while the dump stalls on register 1.
      mem_m[3] = 8'hAA;
      start_dump(3'd0, 4'd0);
      wait_words(1);
      bus.out_ready = 1'b0;
      wait_valid();
      check("t5_stall_addr", {29'd0, rf_read_addr}, 32'd1);
      rf[3] = 8'hAA;
      repeat (3) begin
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      wait_done("t5");

      // Asynchronous reset while word 4 is stalled.
      start_dump(3'd0, 4'd0);
      wait_words(3);
      bus.out_ready = 1'b0;
      wait_valid();
      check("t6_stall_addr", {29'd0, rf_read_addr}, 32'd3);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("t6_rst_busy", {31'd0, busy}, 32'd0);
      check("t6_rst_done", {31'd0, done}, 32'd0);
      check("t6_rst_last", {31'd0, bus.out_last}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("t6_idle_busy", {31'd0, busy}, 32'd0);
      bus.out_ready = 1'b1;
      start_dump(3'd4, 4'd3);
      wait_done("t6");
      check("t6_words", words_seen, 3);

      // Out-of-range count clamps to a full dump.
      start_dump(3'd1, 4'd12);
      wait_done("t7");
      check("t7_words", words_seen, 8);

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
Read-side controller for the 8x8 register file behind the ALU datapath. On a start command it walks a contiguous, wrap-around range of register addresses, samples each word through the register file's combinational read port, and streams the words out over a valid/ready handshake. Used for debug readback and for moving ALU results off-chip; it never writes the register file.

Parameters:
DATA_W, 8, width of one register word
ADDR_W, 3, register address width
NUM_REGS, 8, number of registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a dump; honoured only in IDLE
start_addr  input  ADDR_W  first register to read
count  input  ADDR_W+1  words to read; 0 means NUM_REGS
rf_read_addr  output  ADDR_W  address to the register file read port
rf_read_data  input  DATA_W  combinational read data for rf_read_addr
out_data  output  DATA_W  streamed register word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts the word when high with out_valid
out_last  output  1  qualifies the final word of the dump
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Clock is clk; reset is asynchronous, active-low, named rst_n. Assertion forces IDLE immediately, including mid-dump.
- Reset values: rf_read_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0. Internal address, remaining count and FSM are also cleared.
- FSM states: IDLE, READ, SEND, DONE.
- IDLE: on start=1, latch cur_addr=start_addr. Latch remaining=count, or NUM_REGS if count=0. busy goes 1 next cycle. Go to READ.
- READ (1 cycle): rf_read_addr=cur_addr. At the clock edge, capture out_data<=rf_read_data, set out_valid<=1, set out_last<=(remaining==1). Go to SEND.
- SEND: hold out_data, out_valid and out_last stable until out_valid&&out_ready. On that handshake, clear out_valid and out_last.
  - If remaining>1: decrement remaining, set cur_addr<=cur_addr+1 mod NUM_REGS (7 wraps to 0), go to READ.
  - Else go to DONE.
- DONE (1 cycle): done=1, busy drops to 0 at the exit edge, return to IDLE.
- Latency: start at edge T gives first out_valid at T+2. Throughput is 1 word per 2 cycles with out_ready held high.
- rf_read_addr holds cur_addr in every state. Only the READ-cycle sample is meaningful.
- A register write during a dump is visible only if it lands before that register's READ cycle. No snapshot of the file is taken.
- start while busy or in DONE is ignored and not queued.
- start_addr and count are sampled only on the accepted start cycle.
- out_ready while out_valid=0 has no effect.
- out_data keeps its last value after a dump (not cleared).
- count>NUM_REGS (upper values of the ADDR_W+1 field) is clamped to NUM_REGS.

Decomposition:
- Shared package: DATA_W/ADDR_W/NUM_REGS constants, FSM state enum (IDLE, READ, SEND, DONE), and the count=0 => NUM_REGS rule as a named constant.
- No sub-module required; a single FSM with address and remaining counters. The bench instantiates it against the existing RegisterFile.

Test Plan:
1. Preload regs 0..7 = 0x10..0x17; start_addr=0, count=0; out_ready=1 -> eight words 0x10..0x17 on cycles T+2, T+4, ..., T+16. out_last only with 0x17. done pulses one cycle after the last handshake; busy spans start+1 to done.
2. start_addr=6, count=4 -> words from regs 6, 7, 0, 1 (wrap). out_last on reg 1's word.
3. count=1, out_ready held low 5 cycles after out_valid -> out_data, out_valid and out_last=1 stay stable for all 5 cycles. Single handshake then done.
4. Second start pulse during an active dump with different start_addr -> ignored; stream and word count unchanged.
5. Write reg 3 = 0xAA via Processor while a dump of 0..7 stalls on reg 1 -> reg 3 word reads 0xAA.
6. Assert rst_n low while in SEND on word 4 -> out_valid, busy and done are 0 immediately (asynchronous). After release the FSM is in IDLE and a new start works normally.
